// File: rtl/tmr_voter_monitor_if.sv
// tmr_voter_monitor_if: sample/vote/fault bundle for the TMR voter; mism_cnt_* exist only with TMR_VOTER_STATS_EN
interface tmr_voter_monitor_if #(
    parameter int DATA_W = 16
`ifdef TMR_VOTER_STATS_EN
    , parameter int CNT_W = 8
`endif
);
    logic              in_valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic              clear_fault;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              err_flag;
    logic              uncorrectable;
    logic [5:0]        fault_state;
    logic              sys_fail;
`ifdef TMR_VOTER_STATS_EN
    logic [CNT_W-1:0]  mism_cnt_a;
    logic [CNT_W-1:0]  mism_cnt_b;
    logic [CNT_W-1:0]  mism_cnt_c;
`endif

    modport master (
        output in_valid, a, b, c, clear_fault,
        input  out_valid, out_data, err_flag, uncorrectable, fault_state, sys_fail
`ifdef TMR_VOTER_STATS_EN
        , input mism_cnt_a, mism_cnt_b, mism_cnt_c
`endif
    );

    modport slave (
        input  in_valid, a, b, c, clear_fault,
        output out_valid, out_data, err_flag, uncorrectable, fault_state, sys_fail
`ifdef TMR_VOTER_STATS_EN
        , output mism_cnt_a, mism_cnt_b, mism_cnt_c
`endif
    );
endinterface

// File: rtl/tmr_voter_monitor.sv
// tmr_voter_monitor: registered 2-of-3 word voter with per-replica fault FSMs; TMR_VOTER_STATS_EN adds saturating mismatch counters
module tmr_voter_monitor #(
    parameter int DATA_W      = 16,
    parameter int FAIL_THRESH = 4
`ifdef TMR_VOTER_STATS_EN
    , parameter int CNT_W     = 8
`endif
) (
    input logic clk,
    input logic rst,
    tmr_voter_monitor_if.slave bus
);
    localparam int RW = $clog2(FAIL_THRESH + 1);
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_SUSPECT = 2'b01;
    localparam logic [1:0] ST_FAILED  = 2'b10;

    logic [DATA_W-1:0] vote;
    logic [2:0]        mis;
    logic [2:0]        failed;
    logic              unc;
    logic [5:0]        fs;
`ifdef TMR_VOTER_STATS_EN
    logic [3*CNT_W-1:0] cnts;
`endif

    // bitwise majority and full-word disagreement of each replica with it
    always_comb begin
        vote = (bus.a & bus.b) | (bus.b & bus.c) | (bus.a & bus.c);
        mis  = {bus.c != vote, bus.b != vote, bus.a != vote};
        unc  = (bus.a != bus.b) && (bus.b != bus.c) && (bus.a != bus.c);
    end

    // voted word and its flags are captured only on accepted samples; out_valid pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid     <= 1'b0;
            bus.out_data      <= '0;
            bus.err_flag      <= 1'b0;
            bus.uncorrectable <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out_data      <= vote;
                bus.err_flag      <= |mis;
                bus.uncorrectable <= unc;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_rep
        logic [1:0]    st;
        logic [RW-1:0] run;
        logic [RW-1:0] run_inc;
        // run is 0 whenever OK, so run+1 covers both the first and later mismatches
        assign run_inc = run + 1'b1;
        // fault FSM: clear_fault beats the same-cycle sample, FAILED is sticky
        always_ff @(posedge clk or posedge rst) begin
            if (rst || bus.clear_fault) begin
                st  <= ST_OK;
                run <= '0;
            end else if (bus.in_valid && st != ST_FAILED) begin
                st  <= !mis[g] ? ST_OK : (run_inc == RW'(FAIL_THRESH) ? ST_FAILED : ST_SUSPECT);
                run <= mis[g] ? run_inc : '0;
            end
        end
        assign fs[2*g +: 2] = st;
        assign failed[g]    = st == ST_FAILED;
`ifdef TMR_VOTER_STATS_EN
        logic [CNT_W-1:0] cnt;
        // lifetime mismatch total, saturating, cleared only by rst
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt <= '0;
            else if (bus.in_valid && mis[g] && !(&cnt))
                cnt <= cnt + 1'b1;
        end
        assign cnts[g*CNT_W +: CNT_W] = cnt;
`endif
    end

    assign bus.fault_state = fs;
    assign bus.sys_fail    = (failed[0] & failed[1]) | (failed[1] & failed[2]) | (failed[0] & failed[2]);
`ifdef TMR_VOTER_STATS_EN
    assign bus.mism_cnt_a = cnts[0 +: CNT_W];
    assign bus.mism_cnt_b = cnts[CNT_W +: CNT_W];
    assign bus.mism_cnt_c = cnts[2*CNT_W +: CNT_W];
`endif
endmodule
